// File: rtl/conv3x3_stream_engine_if.sv
// rtl/conv3x3_stream_engine_if.sv - handshake/bus bundle for conv3x3_stream_engine
// Ports: control (i_start, i_shift, i_relu_en), weight write bus (i_wgt_we/addr/data),
// pixel stream in (i_pix_valid, i_pix, o_pix_ready), feature stream out
// (o_valid, o_data, i_out_ready), status (o_busy, o_done).
// slave = engine side, master = driver side.
interface conv3x3_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
);
    logic              i_start;
    logic              i_wgt_we;
    logic [3:0]        i_wgt_addr;
    logic [ACC_W-1:0]  i_wgt_data;
    logic [4:0]        i_shift;
    logic              i_relu_en;
    logic              i_pix_valid;
    logic [DATA_W-1:0] i_pix;
    logic              o_pix_ready;
    logic              o_valid;
    logic [OUT_W-1:0]  o_data;
    logic              i_out_ready;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  i_start, i_wgt_we, i_wgt_addr, i_wgt_data, i_shift, i_relu_en,
        input  i_pix_valid, i_pix, i_out_ready,
        output o_pix_ready, o_valid, o_data, o_busy, o_done
    );

    modport master (
        output i_start, i_wgt_we, i_wgt_addr, i_wgt_data, i_shift, i_relu_en,
        output i_pix_valid, i_pix, i_out_ready,
        input  o_pix_ready, o_valid, o_data, o_busy, o_done
    );
endinterface

// File: rtl/conv3x3_stream_engine.sv
// rtl/conv3x3_stream_engine.sv - streaming 3x3 convolution with runtime weights
// Ports: i_clk (rising edge), i_rst (async active-high), bus (slave modport of
// conv3x3_stream_engine_if: control, weight bus, pixel stream in, feature stream out, status).
module conv3x3_stream_engine #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    conv3x3_stream_engine_if.slave    bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = DATA_W + WGT_W + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic                     adv, accept;
    logic                     pix_ready, busy, done;
    logic [CW-1:0]            col_q;
    logic [RW-1:0]            row_q;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic [DATA_W-1:0]        lb0 [IMG_W];   // row r-2
    logic [DATA_W-1:0]        lb1 [IMG_W];   // row r-1
    logic [DATA_W-1:0]        win [9];       // index 3*row+col, col 2 is newest
    logic signed [WGT_W-1:0]  wgt [9];
    logic signed [ACC_W-1:0]  bias_q;
    logic signed [PW-1:0]     prod [9];
    logic                     win_valid, prod_valid, out_valid_q;
    logic [OUT_W-1:0]         out_data_q;
    logic signed [ACC_W-1:0]  sum, shifted;
    logic [OUT_W-1:0]         post;

    // Every stage moves in lockstep; a stalled output freezes the whole pipe.
    assign adv    = !out_valid_q || bus.i_out_ready;
    assign accept = bus.i_pix_valid && pix_ready;

    assign bus.o_pix_ready = pix_ready;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_valid     = out_valid_q;
    assign bus.o_data      = out_data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: if (bus.i_start) state_d = S_RUN;
            S_RUN: begin
                busy      = 1'b1;
                pix_ready = adv;
                if (bus.i_pix_valid && adv && col_q == COL_LAST && row_q == ROW_LAST)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!win_valid && !prod_valid && !out_valid_q) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sum, shift, ReLU and saturation feeding the output register.
    always_comb begin
        sum = bias_q;
        for (int k = 0; k < 9; k++) sum = sum + ACC_W'(prod[k]);
        shifted = sum >>> shift_q;
        if (relu_q && shifted < 0) shifted = '0;
        if (shifted > SAT_MAX)      post = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN) post = SAT_MIN[OUT_W-1:0];
        else                        post = shifted[OUT_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q       <= '0;
            row_q       <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            win_valid   <= 1'b0;
            prod_valid  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win[k]  <= '0;
                wgt[k]  <= '0;
                prod[k] <= '0;
            end
        end else begin
            if (state_q == S_IDLE && bus.i_start) begin
                col_q   <= '0;
                row_q   <= '0;
                shift_q <= bus.i_shift;
                relu_q  <= bus.i_relu_en;
            end
            if (bus.i_wgt_we && !busy) begin
                if (bus.i_wgt_addr < 4'd9)  wgt[bus.i_wgt_addr] <= bus.i_wgt_data[WGT_W-1:0];
                if (bus.i_wgt_addr == 4'd9) bias_q <= bus.i_wgt_data;
            end
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                lb0[col_q] <= lb1[col_q];
                lb1[col_q] <= bus.i_pix;
                for (int i = 0; i < 3; i++) begin
                    win[3*i]   <= win[3*i+1];
                    win[3*i+1] <= win[3*i+2];
                end
                win[2] <= lb0[col_q];
                win[5] <= lb1[col_q];
                win[8] <= bus.i_pix;
            end
            if (adv) begin
                // Window is complete only once two full columns of this row preceded it.
                win_valid <= accept && row_q >= RW'(2) && col_q >= CW'(2);
                for (int k = 0; k < 9; k++)
                    prod[k] <= PW'($signed({1'b0, win[k]})) * PW'(wgt[k]);
                prod_valid  <= win_valid;
                out_valid_q <= prod_valid;
                out_data_q  <= post;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// tb/tb_conv3x3_stream_engine.sv - self-checking bench for conv3x3_stream_engine
module tb_conv3x3_stream_engine;
    localparam int DATA_W = 8, WGT_W = 8, ACC_W = 24, OUT_W = 8, IMG_W = 5, IMG_H = 4;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
    localparam longint OMAX = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OUT_W - 1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv3x3_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    conv3x3_stream_engine #(
        .DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int img [IMG_H][IMG_W];
    int wm [9];
    int bias_m, shift_m;
    bit relu_m;
    int exp_q[$];
    int got_q[$];
    int done_cnt, stall_viol, first_valid_cyc, acc12_cyc;
    int ramp_exp [NOUT] = '{54, 63, 72, 99, 108, 117};

    // Reference: direct valid-region convolution over the image array.
    function automatic void build_expected();
        longint s;
        exp_q.delete();
        for (int r = 2; r < IMG_H; r++)
            for (int c = 2; c < IMG_W; c++) begin
                s = bias_m;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += longint'(wm[3*i+j]) * longint'(img[r-2+i][c-2+j]);
                s = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
                s = s >>> shift_m;
                if (relu_m && s < 0) s = 0;
                if (s > OMAX) s = OMAX;
                if (s < OMIN) s = OMIN;
                exp_q.push_back(int'(s));
            end
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = 5 * r + c;
    endfunction

    function automatic void fill_const(input int p);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = p;
    endfunction

    function automatic void set_weights(input int w);
        for (int k = 0; k < 9; k++) wm[k] = w;
        bias_m = 0;
    endfunction

    task automatic load_weights();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.i_wgt_we   = 1'b1;
            bus.i_wgt_addr = 4'(k);
            bus.i_wgt_data = (k < 9) ? ACC_W'(wm[k]) : ACC_W'(bias_m);
        end
        @(negedge clk);
        bus.i_wgt_we = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.i_start   = 1'b1;
        bus.i_shift   = 5'(shift_m);
        bus.i_relu_en = relu_m;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Drives one frame and records outputs, stall stability, latency and done pulses.
    task automatic run_frame(input int rdy_pct, input int vld_pct, input int perturb_cyc, input int abort_at);
        int idx, cyc, tail;
        bit prev_stall, aborted;
        logic [OUT_W-1:0] held;
        got_q.delete();
        done_cnt = 0; stall_viol = 0; first_valid_cyc = -1; acc12_cyc = -1;
        idx = 0; cyc = 0; tail = 0; prev_stall = 0; aborted = 0; held = '0;
        while (cyc < 3000 && tail < 4) begin
            @(negedge clk);
            bus.i_start  = 1'b0;
            bus.i_wgt_we = 1'b0;
            if (cyc == perturb_cyc) begin
                bus.i_start    = 1'b1;
                bus.i_wgt_we   = 1'b1;
                bus.i_wgt_addr = 4'd0;
                bus.i_wgt_data = ACC_W'(50);
                bus.i_shift    = 5'd3;
                bus.i_relu_en  = ~relu_m;
            end
            bus.i_out_ready = ($urandom_range(99) < rdy_pct);
            bus.i_pix_valid = !aborted && idx < NPIX && ($urandom_range(99) < vld_pct);
            if (bus.i_pix_valid) bus.i_pix = DATA_W'(img[idx / IMG_W][idx % IMG_W]);
            else                 bus.i_pix = DATA_W'($urandom);
            #1;
            if (prev_stall && (bus.o_valid !== 1'b1 || bus.o_data !== held)) stall_viol++;
            prev_stall = bus.o_valid && !bus.i_out_ready;
            held = bus.o_data;
            if (bus.o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.o_valid && bus.i_out_ready) got_q.push_back(int'($signed(bus.o_data)));
            if (bus.i_pix_valid && bus.o_pix_ready) begin
                if (idx == 2 * IMG_W + 2) acc12_cyc = cyc;
                idx++;
            end
            if (bus.o_done === 1'b1) done_cnt++;
            if (done_cnt > 0 || aborted) tail++;
            if (abort_at > 0 && !aborted && idx == abort_at) begin
                aborted = 1;
                @(negedge clk);
                bus.i_pix_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            cyc++;
        end
        @(negedge clk);
        bus.i_pix_valid = 1'b0;
        bus.i_out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL reset_o_done got=%b exp=0", bus.o_done); end
        checks++; if (bus.o_data !== '0) begin failures++; $display("FAIL reset_o_data got=%0h exp=0", bus.o_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_pix_ready !== 1'b0) begin failures++; $display("FAIL idle_pix_ready got=%b exp=0", bus.o_pix_ready); end
    endtask

    task automatic test_ramp();
        fill_ramp(); set_weights(1); shift_m = 0; relu_m = 0;
        load_weights(); start_frame();
        run_frame(100, 100, -1, 0);
        checks++; if (got_q.size() != NOUT) begin failures++; $display("FAIL ramp_count got=%0d exp=%0d", got_q.size(), NOUT); end
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== ramp_exp[i]) begin
                failures++; $display("FAIL ramp_val[%0d] got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : -9999, ramp_exp[i]);
            end
        end
        checks++; if (first_valid_cyc - acc12_cyc != 3) begin failures++; $display("FAIL ramp_latency got=%0d exp=3", first_valid_cyc - acc12_cyc); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ramp_done got=%0d exp=1", done_cnt); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL ramp_idle_busy got=%b exp=0", bus.o_busy); end
    endtask

    task automatic test_neg_weights();
        for (int rl = 0; rl < 2; rl++) begin
            fill_ramp(); set_weights(-1); shift_m = 0; relu_m = rl[0];
            build_expected();
            load_weights(); start_frame();
            run_frame(100, 100, -1, 0);
            checks++; if (got_q.size() != NOUT) begin failures++; $display("FAIL neg_count relu=%0d got=%0d exp=%0d", rl, got_q.size(), NOUT); end
            for (int i = 0; i < NOUT; i++) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL neg_val relu=%0d [%0d] got=%0d exp=%0d", rl, i, (i < got_q.size()) ? got_q[i] : -9999, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int ws [3] = '{1, 1, -1};
        int ss [3] = '{0, 5, 0};
        int ev [3] = '{127, 71, -128};
        for (int t = 0; t < 3; t++) begin
            fill_const(255); set_weights(ws[t]); shift_m = ss[t]; relu_m = 0;
            load_weights(); start_frame();
            run_frame(100, 100, -1, 0);
            checks++; if (got_q.size() != NOUT) begin failures++; $display("FAIL sat_count case=%0d got=%0d exp=%0d", t, got_q.size(), NOUT); end
            for (int i = 0; i < NOUT; i++) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== ev[t]) begin
                    failures++; $display("FAIL sat_val case=%0d [%0d] got=%0d exp=%0d", t, i, (i < got_q.size()) ? got_q[i] : -9999, ev[t]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        fill_ramp(); set_weights(1); shift_m = 0; relu_m = 0;
        load_weights(); start_frame();
        run_frame(50, 100, -1, 0);
        checks++; if (got_q.size() != NOUT) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), NOUT); end
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== ramp_exp[i]) begin
                failures++; $display("FAIL bp_val[%0d] got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : -9999, ramp_exp[i]);
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_ignored_during_run();
        fill_ramp(); set_weights(1); shift_m = 0; relu_m = 0;
        start_frame();
        run_frame(100, 100, 6, 0);
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== ramp_exp[i]) begin
                failures++; $display("FAIL ign_val[%0d] got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : -9999, ramp_exp[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        fill_ramp(); set_weights(1); shift_m = 0; relu_m = 0;
        load_weights(); start_frame();
        run_frame(100, 100, -1, 7);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL abort_outputs got=%0d exp=0", got_q.size()); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.o_busy); end
        load_weights(); start_frame();
        run_frame(100, 100, -1, 0);
        checks++; if (got_q.size() != NOUT) begin failures++; $display("FAIL rerun_count got=%0d exp=%0d", got_q.size(), NOUT); end
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== ramp_exp[i]) begin
                failures++; $display("FAIL rerun_val[%0d] got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : -9999, ramp_exp[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL rerun_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(255));
            for (int k = 0; k < 9; k++) wm[k] = int'($urandom_range(255)) - 128;
            bias_m  = int'($urandom_range(2097152)) - 1048576;
            shift_m = int'($urandom_range(10));
            relu_m  = $urandom_range(1);
            build_expected();
            load_weights(); start_frame();
            run_frame(60, 70, -1, 0);
            checks++; if (got_q.size() != NOUT) begin failures++; $display("FAIL rand_count f=%0d got=%0d exp=%0d", f, got_q.size(), NOUT); end
            for (int i = 0; i < NOUT; i++) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand_val f=%0d [%0d] got=%0d exp=%0d", f, i, (i < got_q.size()) ? got_q[i] : -9999, exp_q[i]);
                end
            end
            checks++; if (stall_viol != 0) begin failures++; $display("FAIL rand_stall_stable f=%0d got=%0d exp=0", f, stall_viol); end
            checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand_done f=%0d got=%0d exp=1", f, done_cnt); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_wgt_we = 1'b0; bus.i_wgt_addr = '0; bus.i_wgt_data = '0;
        bus.i_shift = '0; bus.i_relu_en = 1'b0; bus.i_pix_valid = 1'b0; bus.i_pix = '0;
        bus.i_out_ready = 1'b1;
        test_reset();
        test_ramp();
        test_neg_weights();
        test_saturation();
        test_backpressure();
        test_ignored_during_run();
        test_reset_abort();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream_engine.md
# conv3x3_stream_engine

Parametrised streaming 3x3 convolution engine: the next-generation replacement for the fixed 28x28 convolution stage inside the accelerator top. It accepts an image as a raster pixel stream with a valid/ready handshake. Weights and bias are loaded at runtime. It emits the valid-region feature map with bias, arithmetic shift, optional ReLU and saturation. Unlike the fixed stage, it has compile-time image size and widths, runtime weights, output backpressure, and a frame-done pulse for the downstream FC stage.

## Interface
- DATA_W, 8: unsigned input pixel width
- WGT_W, 8: signed weight width
- ACC_W, 24: signed accumulator and bias width
- OUT_W, 8: signed output width
- IMG_W, 28: image columns (≥3)
- IMG_H, 28: image rows (≥3)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_wgt_we  in  1  weight/bias write strobe; ignored while o_busy
- i_wgt_addr  in  4  0–8 = weight k (k = 3*row+col of kernel), 9 = bias, 10–15 ignored
- i_wgt_data  in  ACC_W  write data; weights take the low WGT_W bits
- i_shift  in  5  arithmetic right shift applied to the sum; sampled at frame start
- i_relu_en  in  1  ReLU enable; sampled at frame start
- i_pix_valid  in  1  pixel valid
- i_pix  in  DATA_W  pixel
- o_pix_ready  out  1  pixel accepted when i_pix_valid && o_pix_ready
- o_valid  out  1  output valid
- o_data  out  OUT_W  output feature value
- i_out_ready  in  1  downstream ready
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse when the frame's last output is taken

## Operation
- States are IDLE, RUN, DRAIN and DONE.
  - IDLE→RUN on i_start. Column and row counters clear; i_shift and i_relu_en are latched.
  - RUN→DRAIN on acceptance of pixel IMG_W*IMG_H−1.
  - DRAIN→DONE when the pipeline is empty and no output is pending.
  - DONE→IDLE unconditionally. o_done is high in DONE.
- Storage: two line buffers of IMG_W entries each, plus a 3x3 window shift register. The window shifts on every accepted pixel.
- An accepted pixel at (r,c) with r≥2 and c≥2 completes a window. The window centre is (r−1,c−1).
  - Each frame yields exactly (IMG_H−2)*(IMG_W−2) outputs in raster order.
  - There is no padding, and windows never wrap across row boundaries.
- Arithmetic:
  - Products use the signed pixel {1'b0,pix} times the weight.
  - sum = Σ w[k]*p[k] + bias, computed in ACC_W bits with no overflow handling; ACC_W is sized by the user.
  - sum is arithmetically shifted right by the latched shift value.
  - If ReLU is enabled, negative values become 0.
  - The result saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- The pipeline has 3 stages: window, products, sum/post-process into the output register.
  - All stages advance together when adv = !o_valid || i_out_ready.
  - o_pix_ready = adv && state==RUN.
- Weights and bias persist across frames. Reset clears them to 0.

## Timing
- Reset values:
  - state = IDLE.
  - o_valid, o_busy, o_done and o_pix_ready = 0.
  - o_data = 0.
  - Counters, line buffers, window, weights and bias = 0.
- Latency: a window-completing pixel accepted in cycle N gives o_valid=1 in cycle N+3 when there is no stall. Sustained throughput is 1 output/cycle.
- o_data and o_valid hold stable while o_valid && !i_out_ready. No output is dropped or duplicated.
- While stalled, o_pix_ready=0. Pixel values presented with valid low are not consumed.
- i_start in any state other than IDLE is ignored. i_start and i_wgt_we in the same IDLE cycle both take effect; the write applies to the new frame.
- Asserting i_rst mid-frame aborts the frame immediately. No o_done is produced. The next frame restarts at pixel (0,0).

## Test plan
- IMG_W=5, IMG_H=4, all weights 1, bias 0, shift 0, ReLU off, pixels p=5r+c, i_out_ready tied 1 → 6 outputs 54, 63, 72, 99, 108, 117. First output appears 3 cycles after pixel 12 is accepted. o_done pulses once.
- Same image, all weights −1, bias 0: ReLU off → −54 … −117; ReLU on → six 0s.
- All pixels 255, weights 1, bias 0 → shift 0 gives 127 (saturated); shift 5 gives 71; with weights −1 and shift 0 → −128.
- Random i_out_ready with ~50% duty over the ramp frame → identical 6-value sequence, with o_data stable during every stall.
- i_start pulsed during RUN plus i_wgt_we during RUN → both ignored, and results match the unperturbed frame. i_rst asserted after 7 pixels → all outputs 0, then a clean rerun produces the correct 6 values.
